dmem_access_sched: RTL and testbench
====================================

Name: dmem_access_sched

Overview:
- Sequencer driving the control side of the shift-register-queue D memory (relative-difference store for both layers).
- Sweeps the ceil(Z/P) = 20 row-group addresses for layer 0, then layer 1, once per decoding iteration.
- Issues rd_en, rd_address and rd_layer to the D memory.
- Regenerates wr_en after the fixed row-calculation pipeline latency, so D write-backs enter the queue in issue order.
- Handles iteration counting, early termination, drain and the done handshake.

Parameters:
- ADDRESSWIDTH, 5, width of rd_address.
- NCYC, 20, row-group addresses per layer (ceil(511/26)).
- WR_LAT, 3, cycles from a read issue to its D write-back (legal range 1..15).
- ITW, 5, width of the iteration counter and max_iter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin decoding; ignored unless IDLE.
- max_iter  in  ITW  iteration limit, sampled on an accepted start; 0 is treated as 1.
- stall  in  1  freezes issue while high.
- converged  in  1  early-termination flag from the syndrome checker.
- rd_en  out  1  D memory read enable.
- rd_address  out  ADDRESSWIDTH  D memory row-group address.
- rd_layer  out  1  D memory layer select.
- wr_en  out  1  D memory write enable (queue push).
- issue  out  1  slot-valid strobe to the row calculation unit.
- first_iter  out  1  high during iteration 0; tells the row unit that the previous D is invalid.
- iter_count  out  ITW  current iteration index.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately.
  - FSM to IDLE; address, layer and iteration counters to 0; WR_LAT delay line cleared.
  - Reset mid-sweep abandons the sweep; no further wr_en is produced.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE -> SWEEP:
  - On start=1: latch max_iter (0 becomes 1), set busy=1.
  - The first issue is registered in the cycle after start.
- SWEEP, each cycle with stall=0:
  - issue=1, rd_address=addr, rd_layer=layer.
  - rd_en=issue AND NOT first_iter. There is no read in iteration 0 because the memory is empty; write-back still occurs.
  - addr increments 0..NCYC-1.
  - At NCYC-1: addr wraps to 0 and layer toggles.
  - At layer 1 / addr NCYC-1 (end of an iteration):
    - If converged=1 in that cycle, or iter_count = max_iter-1, go to DRAIN.
    - Otherwise iter_count increments and the sweep restarts at layer 0 / addr 0 on the next cycle with no bubble.
  - first_iter=1 iff iter_count=0.
- SWEEP with stall=1:
  - issue=0 and rd_en=0.
  - addr, layer and iter_count hold.
  - rd_address and rd_layer hold their last values.
- WR_LAT delay line:
  - Always advances, independent of stall.
  - wr_en(t) = issue(t-WR_LAT).
  - A stall bubble therefore produces a matching wr_en bubble WR_LAT cycles later.
- DRAIN:
  - issue=0 and rd_en=0.
  - Stays until the delay line is empty (WR_LAT cycles after the last issue), then goes to DONE.
- DONE:
  - done=1 for one cycle, busy falls in the same cycle, then IDLE.
  - iter_count holds the final index until the next accepted start.
- Simultaneous events:
  - start while busy is ignored.
  - converged outside the end-of-iteration cycle is ignored.
  - stall=1 in the end-of-iteration cycle defers the termination decision to the first unstalled cycle at that address.
  - stall in DRAIN has no effect.
- All outputs are registered except rd_en, which is a gate of registered signals.
- Total issues per run = 2*NCYC*(iterations run).

Test Plan:
- Basic sweep: reset, start with max_iter=1 -> 40 issue cycles (layer 0 addr 0..19, then layer 1 addr 0..19); rd_en=0 throughout; wr_en high for 40 cycles starting 3 cycles after the first issue; done 3 cycles after the last issue.
- Two iterations: start with max_iter=2 -> 80 contiguous issues with no bubble between iterations; rd_en=1 only for issues 41..80; first_iter falls at issue 41; iter_count ends at 1.
- Early termination: max_iter=10, converged=1 at iteration 2 layer 1 addr 19 -> DRAIN entered; 120 issues total; done pulse follows; converged pulsed at iteration 1 addr 5 has no effect.
- Stall: stall high for 4 cycles at layer 0 addr 7 -> rd_address holds 7 (the last issued address) with issue=0 for 4 cycles, and a 4-cycle wr_en gap appears 3 cycles later; total wr_en count still 40*iterations.
- Reset mid-operation: rst low at iteration 0 layer 1 addr 10 -> all outputs 0 immediately, no wr_en afterwards; a new start after rst returns high runs a clean sweep from addr 0.
- Edge cases: max_iter=0 behaves as 1; start while busy is ignored; start in the DONE cycle is ignored.

Source files
------------

// File: rtl/dmem_access_sched.sv
// dmem_access_sched: control-side sequencer for the shift-register-queue D memory.
// It sweeps NCYC row-group addresses for layer 0 and then layer 1 in each decoding
// iteration. Each slot goes out as an issue strobe, with a read enable from
// iteration 1 onward. The write-back enable is regenerated WR_LAT cycles after
// each issue, so write-backs enter the queue in the order they were issued.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   start           one-cycle request to begin; only accepted in IDLE
//   max_iter        iteration limit, sampled on an accepted start (0 acts as 1)
//   stall           freezes issue while high
//   converged       early-termination flag, honoured only at the end of an iteration
//   rd_en           D read enable (issue gated off during iteration 0)
//   rd_address      D row-group address of the current or last issued slot
//   rd_layer        D layer select of the current or last issued slot
//   wr_en           D write enable, which is the issue strobe delayed by WR_LAT
//   issue           slot-valid strobe to the row calculation unit
//   first_iter      the issued slot belongs to iteration 0
//   iter_count      iteration index of the issued slot; holds after completion
//   busy            high from an accepted start until done
//   done            one-cycle completion pulse
module dmem_access_sched #(
  parameter int unsigned ADDRESSWIDTH = 5,
  parameter int unsigned NCYC         = 20,
  parameter int unsigned WR_LAT       = 3,
  parameter int unsigned ITW          = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ITW-1:0]          max_iter,
  input  logic                    stall,
  input  logic                    converged,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] rd_address,
  output logic                    rd_layer,
  output logic                    wr_en,
  output logic                    issue,
  output logic                    first_iter,
  output logic [ITW-1:0]          iter_count,
  output logic                    busy,
  output logic                    done
);

  // The drain counter covers WR_LAT up to 15.
  localparam int unsigned DCW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic                    layer_q, layer_d;
  logic [ITW-1:0]          iter_q, iter_d;
  logic [ITW-1:0]          max_q, max_d;
  logic [ADDRESSWIDTH-1:0] rd_address_q, rd_address_d;
  logic                    rd_layer_q, rd_layer_d;
  logic [ITW-1:0]          iter_count_q, iter_count_d;
  logic                    first_iter_q, first_iter_d;
  logic                    issue_q, issue_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WR_LAT-1:0]       dl_q, dl_d;
  logic [DCW-1:0]          drain_q, drain_d;

  logic addr_last;
  logic iter_end;
  logic terminate;

  // Decode the end of the sweep and decide whether to terminate.
  always_comb begin
    addr_last = (addr_q == ADDRESSWIDTH'(NCYC - 1));
    iter_end  = addr_last && layer_q;
    terminate = iter_end && (converged || (iter_q == (max_q - ITW'(1))));
  end

  // Compute the next state and the next value of every register.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    layer_d      = layer_q;
    iter_d       = iter_q;
    max_d        = max_q;
    rd_address_d = rd_address_q;
    rd_layer_d   = rd_layer_q;
    iter_count_d = iter_count_q;
    first_iter_d = first_iter_q;
    issue_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    drain_d      = drain_q;
    // The write-back delay line shifts every cycle, whatever the state or stall.
    dl_d         = WR_LAT'({dl_q, issue_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SWEEP;
          busy_d       = 1'b1;
          max_d        = (max_iter == '0) ? ITW'(1) : max_iter;
          addr_d       = '0;
          layer_d      = 1'b0;
          iter_d       = '0;
          iter_count_d = '0;
          first_iter_d = 1'b1;
        end
      end

      S_SWEEP: begin
        // A stalled cycle issues nothing, and the slot outputs keep the last slot.
        if (!stall) begin
          issue_d      = 1'b1;
          rd_address_d = addr_q;
          rd_layer_d   = layer_q;
          iter_count_d = iter_q;
          first_iter_d = (iter_q == '0);
          if (addr_last) begin
            addr_d  = '0;
            layer_d = ~layer_q;
          end else begin
            addr_d = addr_q + ADDRESSWIDTH'(1);
          end
          if (iter_end) begin
            if (terminate) begin
              state_d = S_DRAIN;
              drain_d = DCW'(WR_LAT - 1);
            end else begin
              iter_d = iter_q + ITW'(1);
            end
          end
        end
      end

      // Wait for the last issue to leave the delay line. The done pulse lines up
      // with its write-back.
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Hold all state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      layer_q      <= 1'b0;
      iter_q       <= '0;
      max_q        <= '0;
      rd_address_q <= '0;
      rd_layer_q   <= 1'b0;
      iter_count_q <= '0;
      first_iter_q <= 1'b0;
      issue_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dl_q         <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      layer_q      <= layer_d;
      iter_q       <= iter_d;
      max_q        <= max_d;
      rd_address_q <= rd_address_d;
      rd_layer_q   <= rd_layer_d;
      iter_count_q <= iter_count_d;
      first_iter_q <= first_iter_d;
      issue_q      <= issue_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dl_q         <= dl_d;
      drain_q      <= drain_d;
    end
  end

  // Iteration 0 finds the memory empty, so it issues without reading.
  assign rd_en      = issue_q & ~first_iter_q;
  assign rd_address = rd_address_q;
  assign rd_layer   = rd_layer_q;
  assign wr_en      = dl_q[WR_LAT-1];
  assign issue      = issue_q;
  assign first_iter = first_iter_q;
  assign iter_count = iter_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dmem_access_sched.sv
// Bench for dmem_access_sched. The stimulus pushes the expected slot sequence
// into a queue. A negedge monitor pops one entry per observed issue, checks
// wr_en against the issue seen WR_LAT cycles earlier, and checks the done pulse.
module tb_dmem_access_sched;

  localparam int unsigned AW     = 5;
  localparam int unsigned NCYC   = 20;
  localparam int unsigned WR_LAT = 3;
  localparam int unsigned ITW    = 5;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic           layer;
    logic           rd_en;
    logic           first;
    logic [ITW-1:0] iter;
  } slot_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [ITW-1:0] max_iter;
  logic           stall;
  logic           converged;
  logic           rd_en;
  logic [AW-1:0]  rd_address;
  logic           rd_layer;
  logic           wr_en;
  logic           issue;
  logic           first_iter;
  logic [ITW-1:0] iter_count;
  logic           busy;
  logic           done;

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_issue_cyc = 0;
  int    wr_cnt = 0;
  int    done_cnt = 0;
  logic [WR_LAT-1:0] hist = '0;

  dmem_access_sched #(
    .ADDRESSWIDTH(AW),
    .NCYC        (NCYC),
    .WR_LAT      (WR_LAT),
    .ITW         (ITW)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .max_iter  (max_iter),
    .stall     (stall),
    .converged (converged),
    .rd_en     (rd_en),
    .rd_address(rd_address),
    .rd_layer  (rd_layer),
    .wr_en     (wr_en),
    .issue     (issue),
    .first_iter(first_iter),
    .iter_count(iter_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queue and the issue history.
  always @(negedge clk) begin
    slot_t e;
    slot_t a;
    cyc++;
    if (!rst_n) begin
      hist = '0;
    end else begin
      if (wr_en || hist[WR_LAT-1]) chk("wr_en_vs_issue_delayed", 32'(wr_en), 32'(hist[WR_LAT-1]));
      if (wr_en) wr_cnt++;
      hist = {hist[WR_LAT-2:0], issue};
      if (!issue && rd_en) chk("rd_en_without_issue", 32'(rd_en), 32'd0);
      if (issue) begin
        last_issue_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = '{addr: rd_address, layer: rd_layer, rd_en: rd_en, first: first_iter, iter: iter_count};
          chk("issue_slot", 32'(a), 32'(e));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_gap_after_last_issue", 32'(cyc - last_issue_cyc), 32'(WR_LAT));
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("no_pending_slots_at_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic push_slots(input int n_iter);
    for (int it = 0; it < n_iter; it++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < int'(NCYC); a++)
          exp_q.push_back('{addr: AW'(a), layer: l[0], rd_en: (it != 0),
                            first: (it == 0), iter: ITW'(it)});
  endtask

  task automatic outputs_zero(input string nm);
    chk(nm, 32'({rd_en, rd_address, rd_layer, wr_en, issue, first_iter, iter_count, busy, done}),
        32'd0);
  endtask

  // One decoding run. Cycle c=1 is the cycle after start was sampled, and the
  // slot with global index g is decided in cycle 1+g when there is no stall.
  task automatic run(input logic [ITW-1:0] mi, input int n_iter, input int conv_cyc,
                     input int stall_cyc, input int stall_len,
                     input bit start_busy, input bit start_in_done);
    int c;
    bit seen;
    push_slots(n_iter);
    wr_cnt   = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    max_iter = mi;
    @(posedge clk); #1;
    start    = 1'b0;
    max_iter = 5'd7;
    c        = 1;
    seen     = 1'b0;
    while (!seen && c < 400) begin
      if (stall_len > 0 && c > stall_cyc && c <= stall_cyc + stall_len) begin
        chk("issue_low_in_stall", 32'(issue), 32'd0);
        chk("rd_address_held_in_stall", 32'(rd_address), 32'(stall_cyc - 2));
      end
      converged = (c == conv_cyc) || (c == 46);
      stall     = (c >= stall_cyc) && (c < stall_cyc + stall_len);
      start     = start_busy && (c == 20);
      max_iter  = (start_busy && c == 20) ? ITW'(1) : ITW'(7);
      @(posedge clk); #1;
      c++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    converged = 1'b0;
    stall     = 1'b0;
    start     = start_in_done;
    max_iter  = ITW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("wr_en_total", 32'(wr_cnt), 32'(2 * NCYC * n_iter));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("final_iter_count", 32'(iter_count), 32'(n_iter - 1));
    chk("slots_left", 32'(exp_q.size()), 32'd0);
    chk("idle_no_issue", 32'(issue), 32'd0);
  endtask

  // Reset at iteration 0, layer 1, address 10 (slot 30 is visible in cycle 32).
  task automatic reset_mid();
    int c;
    push_slots(1);
    @(posedge clk); #1;
    start    = 1'b1;
    max_iter = ITW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 32) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pre_reset_addr", 32'({rd_layer, rd_address}), 32'({1'b1, 5'd10}));
    rst_n = 1'b0;
    #1;
    outputs_zero("outputs_zero_on_async_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    wr_cnt = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("no_wr_en_after_reset", 32'(wr_cnt), 32'd0);
    chk("busy_low_after_reset", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    max_iter  = '0;
    stall     = 1'b0;
    converged = 1'b0;
    #12;
    outputs_zero("reset_outputs_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    outputs_zero("reset_outputs_after_release");

    run(ITW'(1),  1, -1, 1000, 0, 1'b0, 1'b1);  // basic sweep, plus a start in the DONE cycle
    run(ITW'(2),  2, -1, 1000, 0, 1'b1, 1'b0);  // two iterations, plus a start while busy
    run(ITW'(10), 3, 120, 1000, 0, 1'b0, 1'b0); // converged at iteration 2, layer 1, addr 19
    run(ITW'(1),  1, -1, 9, 4, 1'b0, 1'b0);     // 4-cycle stall at layer 0, addr 8
    reset_mid();
    run(ITW'(1),  1, -1, 1000, 0, 1'b0, 1'b0);  // clean sweep after the reset
    run(ITW'(0),  1, -1, 1000, 0, 1'b0, 1'b0);  // max_iter=0 acts as 1

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
